// File: rtl/integral_row_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : integral_row_scheduler
//  Description : Frame sequencer that feeds a chain of row line buffers
//                for integral-image window computation. Accepts pixels from
//                upstream, tracks the column and row position, flags complete
//                windows, and signals the end of each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module integral_row_scheduler #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int NUM_ROWS     = 24,
    parameter int WINDOW_WIDTH = 24,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH_8 = 8
) (
    input  logic                    clk_os,
    input  logic                    reset_os,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_pixel_valid,
    input  logic [DATA_WIDTH_8-1:0] i_pixel,
    output logic                    o_pixel_ready,
    output logic                    o_row_wen,
    output logic [DATA_WIDTH_8-1:0] o_row_data,
    output logic                    o_row_clear,
    output logic [ADDR_WIDTH-1:0]   o_fifo_width,
    output logic [ADDR_WIDTH-1:0]   o_col,
    output logic [ADDR_WIDTH-1:0]   o_row,
    output logic                    o_window_valid,
    output logic                    o_frame_done,
    output logic                    o_busy
);

    // Position limits for wrap detection and window completion.
    localparam logic [ADDR_WIDTH-1:0] c_COL_LAST  = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_LAST  = ADDR_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_MIN   = ADDR_WIDTH'(NUM_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_COL_MIN   = ADDR_WIDTH'(WINDOW_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_FIFO_WIDE = ADDR_WIDTH'(FRAME_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_col;
    logic [ADDR_WIDTH-1:0]   r_row;
    logic                    r_row_wen;
    logic [DATA_WIDTH_8-1:0] r_row_data;
    logic                    r_row_clear;
    logic                    r_window_valid;
    logic                    r_frame_done;

    logic w_ready;
    logic w_accept;
    logic w_col_last;
    logic w_row_last;
    logic w_win_hit;

    // Handshake and position decode; abort blocks acceptance in the same cycle.
    always_comb begin
        w_ready    = (r_state == S_STREAM) && !i_abort;
        w_accept   = w_ready && i_pixel_valid;
        w_col_last = (r_col == c_COL_LAST);
        w_row_last = (r_row == c_ROW_LAST);
        w_win_hit  = (r_row >= c_ROW_MIN) && (r_col >= c_COL_MIN);
    end

    // Frame sequencer with registered row-buffer write, clear and done outputs.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            r_state        <= S_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_row_wen      <= 1'b0;
            r_row_data     <= '0;
            r_row_clear    <= 1'b0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            // Write path is independent of the state update so a write scheduled
            // by the previous acceptance still issues during an abort cycle.
            r_row_wen      <= w_accept;
            r_window_valid <= w_accept && w_win_hit;
            if (w_accept) begin
                r_row_data <= i_pixel;
            end
            r_row_clear  <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_CLEAR;
                        r_row_clear <= 1'b1;
                        r_col       <= '0;
                        r_row       <= '0;
                    end
                end
                S_CLEAR: begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= i_abort ? S_IDLE : S_STREAM;
                end
                S_STREAM: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_col   <= '0;
                        r_row   <= '0;
                    end else if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row        <= '0;
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_row <= r_row + ADDR_WIDTH'(1);
                            end
                        end else begin
                            r_col <= r_col + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Single-cycle done; abort here lands in IDLE just the same.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pixel_ready  = w_ready;
    assign o_row_wen      = r_row_wen;
    assign o_row_data     = r_row_data;
    assign o_row_clear    = r_row_clear;
    assign o_fifo_width   = c_FIFO_WIDE;
    assign o_col          = r_col;
    assign o_row          = r_row;
    assign o_window_valid = r_window_valid;
    assign o_frame_done   = r_frame_done;
    assign o_busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_integral_row_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_integral_row_scheduler
//  Description : Self-checking bench for integral_row_scheduler on an 8x4
//                frame with a 3x3 window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_integral_row_scheduler;

    localparam int FW = 8;
    localparam int FH = 4;
    localparam int NR = 3;
    localparam int WW = 3;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int NPIX = FW * FH;

    logic          clk_os = 1'b0;
    logic          reset_os = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_pixel_valid = 1'b0;
    logic [DW-1:0] i_pixel = '0;
    logic          o_pixel_ready;
    logic          o_row_wen;
    logic [DW-1:0] o_row_data;
    logic          o_row_clear;
    logic [AW-1:0] o_fifo_width;
    logic [AW-1:0] o_col;
    logic [AW-1:0] o_row;
    logic          o_window_valid;
    logic          o_frame_done;
    logic          o_busy;

    integral_row_scheduler #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .NUM_ROWS    (NR),
        .WINDOW_WIDTH(WW),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH_8(DW)
    ) u_dut (
        .clk_os        (clk_os),
        .reset_os      (reset_os),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_pixel_valid (i_pixel_valid),
        .i_pixel       (i_pixel),
        .o_pixel_ready (o_pixel_ready),
        .o_row_wen     (o_row_wen),
        .o_row_data    (o_row_data),
        .o_row_clear   (o_row_clear),
        .o_fifo_width  (o_fifo_width),
        .o_col         (o_col),
        .o_row         (o_row),
        .o_window_valid(o_window_valid),
        .o_frame_done  (o_frame_done),
        .o_busy        (o_busy)
    );

    always #5 clk_os = ~clk_os;

    int nchk = 0;
    int errs = 0;

    // Observation of row-buffer traffic, sampled on the falling edge.
    logic [DW-1:0] q_wr[$];
    logic          q_wv[$];
    int            n_clear = 0;
    int            n_done = 0;
    int            n_stray_wv = 0;
    int            done_at = -1;

    always @(negedge clk_os) begin
        if (o_row_wen) begin
            q_wr.push_back(o_row_data);
            q_wv.push_back(o_window_valid);
        end else if (o_window_valid) begin
            n_stray_wv <= n_stray_wv + 1;
        end
        if (o_row_clear) n_clear <= n_clear + 1;
        if (o_frame_done) begin
            n_done  <= n_done + 1;
            done_at <= q_wr.size();
        end
    end

    task automatic tick();
        @(posedge clk_os);
        #1;
    endtask

    // Reference: window complete when pixel index lies at row>=NR-1, col>=WW-1.
    function automatic logic exp_win(input int idx);
        return ((idx / FW) >= NR - 1) && ((idx % FW) >= WW - 1);
    endfunction

    task automatic test_reset();
        reset_os = 1'b0;
        #2;
        nchk++;
        if ({o_pixel_ready, o_row_wen, o_row_data, o_row_clear, o_col, o_row,
             o_window_valid, o_frame_done, o_busy} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got wen=%0b data=%0h col=%0d row=%0d busy=%0b, required all 0",
                     o_row_wen, o_row_data, o_col, o_row, o_busy);
        end
        nchk++;
        if (o_fifo_width !== AW'(FW)) begin
            errs++;
            $display("FAIL reset_fifo_width: got %0d required %0d", o_fifo_width, FW);
        end
        tick();
        tick();
        reset_os = 1'b1;
        tick();
        nchk++;
        if (o_busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_release_idle: busy got %0b required 0", o_busy);
        end
    endtask

    // mode 0: back-to-back 0..31, mode 1: valid every other cycle,
    // mode 2: random valid with stray i_start pulses while streaming.
    task automatic run_frame(input int mode, input string tag);
        logic [DW-1:0] pix[NPIX];
        int base_wr, base_clr, base_done, base_stray, idx, cyc, nw;
        logic v;
        for (int i = 0; i < NPIX; i++)
            pix[i] = (mode == 0) ? DW'(i) : DW'($urandom_range(0, 255));
        base_wr = q_wr.size();
        base_clr = n_clear;
        base_done = n_done;
        base_stray = n_stray_wv;

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        // CLEAR cycle: a valid pixel offered here must be ignored.
        i_pixel_valid = 1'b1;
        i_pixel = 8'hEE;
        #1;
        nchk++;
        if (o_row_clear !== 1'b1 || o_pixel_ready !== 1'b0 || o_busy !== 1'b1 ||
            o_col !== '0 || o_row !== '0) begin
            errs++;
            $display("FAIL %s clear_cycle: got clr=%0b rdy=%0b busy=%0b col=%0d row=%0d, required 1 0 1 0 0",
                     tag, o_row_clear, o_pixel_ready, o_busy, o_col, o_row);
        end
        tick();

        idx = 0;
        cyc = 0;
        while (idx < NPIX && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'(($urandom_range(0, 3)) != 0);
            endcase
            i_pixel_valid = v;
            i_pixel = pix[idx];
            i_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            nchk++;
            if (o_pixel_ready !== 1'b1 || o_col !== AW'(idx % FW) || o_row !== AW'(idx / FW)) begin
                errs++;
                $display("FAIL %s position: idx=%0d got rdy=%0b col=%0d row=%0d, required 1 %0d %0d",
                         tag, idx, o_pixel_ready, o_col, o_row, idx % FW, idx / FW);
            end
            tick();
            if (v) idx++;
            cyc++;
        end
        i_pixel_valid = 1'b0;
        i_start = 1'b0;
        nchk++;
        if (idx != NPIX) begin
            errs++;
            $display("FAIL %s timeout: accepted %0d required %0d", tag, idx, NPIX);
        end
        // Now in DONE; let it settle back to IDLE.
        tick();
        tick();
        nchk++;
        if (o_busy !== 1'b0 || o_col !== '0 || o_row !== '0) begin
            errs++;
            $display("FAIL %s end_idle: got busy=%0b col=%0d row=%0d, required 0 0 0",
                     tag, o_busy, o_col, o_row);
        end

        nw = q_wr.size() - base_wr;
        nchk++;
        if (nw != NPIX) begin
            errs++;
            $display("FAIL %s write_count: got %0d required %0d", tag, nw, NPIX);
        end
        for (int i = 0; i < NPIX && i < nw; i++) begin
            nchk++;
            if (q_wr[base_wr + i] !== pix[i] || q_wv[base_wr + i] !== exp_win(i)) begin
                errs++;
                $display("FAIL %s write[%0d]: got data=%0h win=%0b, required data=%0h win=%0b",
                         tag, i, q_wr[base_wr + i], q_wv[base_wr + i], pix[i], exp_win(i));
            end
        end
        nchk++;
        if (n_clear - base_clr != 1 || n_done - base_done != 1 || done_at - base_wr != NPIX ||
            n_stray_wv != base_stray) begin
            errs++;
            $display("FAIL %s pulses: got clears=%0d dones=%0d done_at=%0d stray_win=%0d, required 1 1 %0d 0",
                     tag, n_clear - base_clr, n_done - base_done, done_at - base_wr,
                     n_stray_wv - base_stray, NPIX);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(0, "back_to_back");
    endtask

    task automatic test_alternate_valid();
        run_frame(1, "alternate");
    endtask

    task automatic test_random_start_in_stream();
        run_frame(2, "random");
    endtask

    task automatic test_idle_ignores_valid();
        int base_wr;
        base_wr = q_wr.size();
        for (int i = 0; i < 4; i++) begin
            i_pixel_valid = 1'b1;
            i_pixel = DW'($urandom_range(0, 255));
            #1;
            nchk++;
            if (o_pixel_ready !== 1'b0 || o_row_wen !== 1'b0 || o_busy !== 1'b0) begin
                errs++;
                $display("FAIL idle_valid: got rdy=%0b wen=%0b busy=%0b, required 0 0 0",
                         o_pixel_ready, o_row_wen, o_busy);
            end
            tick();
        end
        i_pixel_valid = 1'b0;
        tick();
        nchk++;
        if (q_wr.size() != base_wr) begin
            errs++;
            $display("FAIL idle_writes: got %0d required 0", q_wr.size() - base_wr);
        end
    endtask

    task automatic test_abort();
        int base_wr, base_done;
        base_wr = q_wr.size();
        base_done = n_done;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        for (int i = 0; i < 13; i++) begin
            i_pixel_valid = 1'b1;
            i_pixel = DW'(i);
            tick();
        end
        i_pixel = DW'(13);
        i_abort = 1'b1;
        #1;
        nchk++;
        if (o_pixel_ready !== 1'b0 || o_row_wen !== 1'b1 || o_row_data !== DW'(12)) begin
            errs++;
            $display("FAIL abort_cycle: got rdy=%0b wen=%0b data=%0d, required 0 1 12",
                     o_pixel_ready, o_row_wen, o_row_data);
        end
        tick();
        i_abort = 1'b0;
        i_pixel_valid = 1'b0;
        nchk++;
        if (o_busy !== 1'b0 || o_col !== '0 || o_row !== '0 || o_row_wen !== 1'b0 ||
            o_row_data !== DW'(12)) begin
            errs++;
            $display("FAIL abort_after: got busy=%0b col=%0d row=%0d wen=%0b data=%0d, required 0 0 0 0 12",
                     o_busy, o_col, o_row, o_row_wen, o_row_data);
        end
        tick();
        tick();
        tick();
        nchk++;
        if (q_wr.size() - base_wr != 13 || n_done != base_done) begin
            errs++;
            $display("FAIL abort_totals: got writes=%0d dones=%0d, required 13 0",
                     q_wr.size() - base_wr, n_done - base_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base_done;
        base_done = n_done;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            i_pixel_valid = 1'b1;
            i_pixel = DW'($urandom_range(1, 255));
            tick();
        end
        i_pixel_valid = 1'b0;
        #2;
        reset_os = 1'b0;
        #1;
        nchk++;
        if ({o_pixel_ready, o_row_wen, o_row_data, o_row_clear, o_col, o_row,
             o_window_valid, o_frame_done, o_busy} !== '0 || o_fifo_width !== AW'(FW)) begin
            errs++;
            $display("FAIL midframe_reset: got wen=%0b data=%0h col=%0d row=%0d busy=%0b fifo=%0d, required 0 0 0 0 0 %0d",
                     o_row_wen, o_row_data, o_col, o_row, o_busy, o_fifo_width, FW);
        end
        tick();
        tick();
        reset_os = 1'b1;
        tick();
        tick();
        nchk++;
        if (o_busy !== 1'b0 || n_done != base_done) begin
            errs++;
            $display("FAIL midframe_after: got busy=%0b dones=%0d, required 0 0",
                     o_busy, n_done - base_done);
        end
        run_frame(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alternate_valid();
        test_idle_ignores_valid();
        test_random_start_in_stream();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/integral_row_scheduler.md
INTEGRAL_ROW_SCHEDULER -- requirements
Module: integral_row_scheduler

Interface
REQ-001 The block SHALL have parameter FRAME_WIDTH, default 640: pixels per image line.
REQ-002 The block SHALL have parameter FRAME_HEIGHT, default 480: lines per frame.
REQ-003 The block SHALL have parameter NUM_ROWS, default 24: chained row line buffers, equal to the window height.
REQ-004 The block SHALL have parameter WINDOW_WIDTH, default 24: window width in pixels.
REQ-005 The block SHALL have parameter ADDR_WIDTH, default 10: counter and FIFO-depth width.
REQ-006 The block SHALL have parameter DATA_WIDTH_8, default 8: pixel width.
REQ-007 The block SHALL have port clk_os, input, 1: sole clock, all logic on the rising edge.
REQ-008 The block SHALL have port reset_os, input, 1: asynchronous, active-low reset.
REQ-009 The block SHALL have port i_start, input, 1: frame start request.
REQ-010 The block SHALL have port i_abort, input, 1: abort the current frame.
REQ-011 The block SHALL have port i_pixel_valid, input, 1: upstream pixel valid.
REQ-012 The block SHALL have port i_pixel, input, DATA_WIDTH_8: upstream pixel.
REQ-013 The block SHALL have port o_pixel_ready, output, 1: pixel accept.
REQ-014 The block SHALL have port o_row_wen, output, 1: write enable to every chained row.
REQ-015 The block SHALL have port o_row_data, output, DATA_WIDTH_8: pixel driven into the first row FIFO.
REQ-016 The block SHALL have port o_row_clear, output, 1: one-cycle synchronous clear of row integrals.
REQ-017 The block SHALL have port o_fifo_width, output, ADDR_WIDTH: row FIFO read threshold, constant FRAME_WIDTH.
REQ-018 The block SHALL have ports o_col and o_row, output, ADDR_WIDTH each: position of the next expected pixel.
REQ-019 The block SHALL have port o_window_valid, output, 1: the window ending at the written pixel is complete.
REQ-020 The block SHALL have ports o_frame_done and o_busy, output, 1 each: end-of-frame pulse and not-idle flag.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, CLEAR, STREAM, DONE.
REQ-022 In IDLE, i_start=1 SHALL move the FSM to CLEAR; i_start SHALL be ignored in every other state.
REQ-023 CLEAR SHALL last one cycle, assert o_row_clear, zero o_col and o_row, then move to STREAM.
REQ-024 o_pixel_ready SHALL equal (state==STREAM) AND NOT i_abort, combinationally.
REQ-025 A pixel SHALL be accepted only on a cycle where i_pixel_valid=1 and o_pixel_ready=1; valid without ready SHALL have no effect.
REQ-026 One cycle after acceptance, o_row_wen SHALL be 1 with o_row_data equal to the accepted pixel; otherwise o_row_wen SHALL be 0 and o_row_data SHALL hold its last value.
REQ-027 On acceptance, o_col SHALL increment; at FRAME_WIDTH-1 it SHALL wrap to 0 and o_row SHALL increment.
REQ-028 o_window_valid SHALL be registered and aligned with o_row_wen.
REQ-029 o_window_valid SHALL be 1 iff the accepted pixel had row>=NUM_ROWS-1 and col>=WINDOW_WIDTH-1.
REQ-030 Acceptance at row FRAME_HEIGHT-1, col FRAME_WIDTH-1 SHALL move the FSM to DONE, with o_col and o_row wrapping to 0.
REQ-031 DONE SHALL last one cycle with o_frame_done=1, then return to IDLE.
REQ-032 i_abort=1 in CLEAR, STREAM or DONE SHALL force IDLE on the next edge.
REQ-033 On abort, no pixel SHALL be accepted that cycle, no o_frame_done SHALL be produced, and o_col and o_row SHALL reset to 0.
REQ-034 An o_row_wen already scheduled from the previous cycle SHALL still issue when i_abort is asserted.
REQ-035 o_busy SHALL be 1 in every state except IDLE.
REQ-036 Counters SHALL be ADDR_WIDTH-bit unsigned; FRAME_WIDTH and FRAME_HEIGHT SHALL each be <= 2^ADDR_WIDTH.

Reset
REQ-037 reset_os=0 SHALL immediately force IDLE and drive all outputs to 0, except o_fifo_width=FRAME_WIDTH.
REQ-038 Assertion of reset_os mid-frame SHALL discard the frame with no o_frame_done.
REQ-039 After deassertion, the first frame SHALL require a new i_start.

Verification (FRAME_WIDTH=8, FRAME_HEIGHT=4, NUM_ROWS=3, WINDOW_WIDTH=3)
REQ-040 Bench SHALL cover: i_start pulse, then 32 back-to-back valid pixels 0..31 -> o_row_clear once, o_row_wen for 32 cycles with data 0..31, o_window_valid for pixels 18-23 and 26-31 (12 cycles), o_frame_done exactly once after pixel 31.
REQ-041 Bench SHALL cover: i_pixel_valid toggled every other cycle -> identical o_row_data sequence, o_col 7->0 wrap with o_row increment after pixel 7.
REQ-042 Bench SHALL cover: i_abort together with valid pixel 13 -> pixel not accepted, IDLE next cycle, o_row=0, o_col=0, no o_frame_done.
REQ-043 Bench SHALL cover: i_start during STREAM and i_pixel_valid during IDLE -> no state change, o_row_wen stays 0.
REQ-044 Bench SHALL cover: reset_os low after 10 pixels -> all outputs 0 asynchronously, o_fifo_width=8, o_busy=0; then a new frame completes normally.
